// File: rtl/cache_pkg.sv
// cache_pkg: geometry constants and index/age types shared by the cache data, way-tag and LRU blocks
package cache_pkg;
  localparam int CACHE_SET_ADDR_W = 9;
  localparam int CACHE_WAY_W = 2;
  localparam int CACHE_NUM_WAYS = 2**CACHE_WAY_W;
  typedef logic [CACHE_WAY_W-1:0] way_idx_t;
  typedef logic [CACHE_SET_ADDR_W-1:0] set_idx_t;
  typedef way_idx_t [CACHE_NUM_WAYS-1:0] lru_ages_t;
endpackage

// File: rtl/cache_lru_if.sv
// cache_lru_if: access report in, refill victim out, between the memory system and the LRU tracker
interface cache_lru_if import cache_pkg::*; #(
  parameter int SET_ADDR_W = CACHE_SET_ADDR_W,
  parameter int WAY_W = CACHE_WAY_W
);
  logic [SET_ADDR_W-1:0] lru_addr;
  logic [WAY_W-1:0] lru_used_index;
  logic [WAY_W-1:0] lru_least_used_way;
  logic enable;
  modport master (output lru_addr, output lru_used_index, output enable, input lru_least_used_way);
  modport slave (input lru_addr, input lru_used_index, input enable, output lru_least_used_way);
endinterface

// File: rtl/cache_lru_age_update.sv
// cache_lru_age_update: next true-LRU ages of one set after touching used_way, plus its oldest way
module cache_lru_age_update import cache_pkg::*; #(
  parameter int WAY_W = CACHE_WAY_W,
  localparam int NUM_WAYS = 2**WAY_W
) (
  input  logic [NUM_WAYS-1:0][WAY_W-1:0] old_ages,
  input  logic [WAY_W-1:0] used_way,
  output logic [NUM_WAYS-1:0][WAY_W-1:0] new_ages,
  output logic [WAY_W-1:0] oldest_way
);
  logic [WAY_W-1:0] used_age;
  assign used_age = old_ages[used_way];
  // Only ways younger than the touched one age, which keeps the set a permutation
  always_comb begin
    new_ages = old_ages;
    oldest_way = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      new_ages[w] = (WAY_W'(w) == used_way) ? '0 :
                    (old_ages[w] < used_age) ? old_ages[w] + 1'b1 : old_ages[w];
      if (old_ages[w] == WAY_W'(NUM_WAYS-1)) oldest_way = WAY_W'(w);
    end
  end
endmodule

// File: rtl/cache_lru.sv
// cache_lru: per-set true-LRU tracker with zero-latency victim lookup; CACHE_LRU_CHECK_EN adds simulation checks
module cache_lru import cache_pkg::*; #(
  parameter int SET_ADDR_W = CACHE_SET_ADDR_W,
  parameter int WAY_W = CACHE_WAY_W
) (
  input logic main_clk,
  input logic rst,
  cache_lru_if.slave bus
);
  localparam int NUM_WAYS = 2**WAY_W;
  localparam int NUM_SETS = 2**SET_ADDR_W;
  logic [NUM_WAYS-1:0][WAY_W-1:0] ages [NUM_SETS];
  logic [NUM_WAYS-1:0][WAY_W-1:0] new_ages;
  cache_lru_age_update #(.WAY_W(WAY_W)) u_age (
    .old_ages(ages[bus.lru_addr]),
    .used_way(bus.lru_used_index),
    .new_ages(new_ages),
    .oldest_way(bus.lru_least_used_way)
  );
  // Cold sets hand out victims in way order 0,1,2,...
  always_ff @(posedge main_clk or posedge rst)
    if (rst) begin
      for (int s = 0; s < NUM_SETS; s++)
        for (int w = 0; w < NUM_WAYS; w++)
          ages[s][w] <= WAY_W'(NUM_WAYS-1-w);
    end else if (bus.enable) begin
      ages[bus.lru_addr] <= new_ages;
    end
`ifdef CACHE_LRU_CHECK_EN
  function automatic bit is_perm(input logic [NUM_WAYS-1:0][WAY_W-1:0] a);
    logic [NUM_WAYS-1:0] seen;
    seen = '0;
    for (int w = 0; w < NUM_WAYS; w++) seen[a[w]] = 1'b1;
    return &seen;
  endfunction
  always @(posedge main_clk)
    if (!rst) begin
      if ($isunknown(bus.enable))
        $error("cache_lru: enable is X/Z at set %0d", bus.lru_addr);
      else if (bus.enable) begin
        if ($isunknown({bus.lru_addr, bus.lru_used_index}))
          $error("cache_lru: X/Z on lru_addr %0d / lru_used_index %0d", bus.lru_addr, bus.lru_used_index);
        else if (!is_perm(new_ages))
          $error("cache_lru: set %0d ages %h not a permutation", bus.lru_addr, new_ages);
      end
    end
`endif
endmodule

// File: tb/tb_cache_lru.sv
// tb_cache_lru: directed scoreboard bench for the per-set true-LRU tracker
module tb_cache_lru;
  import cache_pkg::*;
  logic main_clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int passed = 0;
  string tag_q[$];
  way_idx_t exp_q[$];
  cache_lru_if bus();
  cache_lru dut (.main_clk(main_clk), .rst(rst), .bus(bus.slave));
  always #5 main_clk = ~main_clk;
  task automatic push(input string tag, input way_idx_t e);
    tag_q.push_back(tag);
    exp_q.push_back(e);
  endtask
  task automatic pop_check();
    string t;
    way_idx_t e;
    t = tag_q.pop_front();
    e = exp_q.pop_front();
    checks++;
    assert (bus.lru_least_used_way === e) passed++;
    else $error("FAIL %s: observed %0d expected %0d", t, bus.lru_least_used_way, e);
  endtask
  task automatic look(input int set, input way_idx_t e, input string tag);
    bus.enable = 1'b0;
    bus.lru_addr = set_idx_t'(set);
    push(tag, e);
    #1;
    pop_check();
  endtask
  // Leaves enable high so consecutive touches land on consecutive edges
  task automatic touch(input int set, input int way);
    @(negedge main_clk);
    bus.lru_addr = set_idx_t'(set);
    bus.lru_used_index = way_idx_t'(way);
    bus.enable = 1'b1;
    @(posedge main_clk);
    #1;
  endtask
  initial begin
    bus.enable = 1'b0;
    bus.lru_addr = '0;
    bus.lru_used_index = '0;
    #1;
    look(0, 0, "in_reset");
    repeat (2) @(negedge main_clk);
    rst = 1'b0;
    for (int s = 0; s < 512; s++) look(s, 0, $sformatf("sweep_%0d", s));
    touch(5, 0);
    look(5, 1, "s5_after_w0");
    touch(5, 1);
    touch(5, 2);
    look(5, 3, "s5_after_w012");
    touch(5, 3);
    look(5, 0, "s5_after_w3");
    look(6, 0, "s6_untouched");
    touch(9, 2);
    touch(9, 0);
    touch(9, 3);
    touch(9, 1);
    look(9, 2, "s9_b2b");
    @(negedge main_clk);
    bus.lru_addr = 9'd9;
    bus.lru_used_index = 2'd2;
    bus.enable = 1'b1;
    push("s9_pre_edge", 2);
    #1;
    pop_check();
    @(posedge main_clk);
    #1;
    push("s9_post_edge", 0);
    pop_check();
    for (int i = 0; i < 10; i++) begin
      @(negedge main_clk);
      bus.enable = 1'b0;
      bus.lru_used_index = 'x;
      bus.lru_addr = 9'd5;
      push($sformatf("s5_idle_%0d", i), 0);
      #1;
      pop_check();
    end
    checks++;
    assert (!$isunknown(bus.lru_least_used_way)) passed++;
    else $error("FAIL no_x: observed %b expected known", bus.lru_least_used_way);
    touch(5, 0);
    look(5, 1, "s5_held_then_w0");
    touch(3, 0);
    look(3, 1, "s3_w0");
    touch(3, 0);
    look(3, 1, "s3_w0_again");
    touch(3, 1);
    look(3, 2, "s3_then_w1");
    touch(7, 0);
    touch(7, 1);
    look(7, 2, "s7_before_rst");
    @(negedge main_clk);
    bus.lru_addr = 9'd7;
    bus.lru_used_index = 2'd0;
    bus.enable = 1'b1;
    #2 rst = 1'b1;
    push("rst_immediate", 0);
    #1;
    pop_check();
    @(posedge main_clk);
    #1;
    bus.enable = 1'b0;
    rst = 1'b0;
    look(7, 0, "rst_drops_update");
    look(5, 0, "rst_clears_s5");
    look(3, 0, "rst_clears_s3");
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
